// File: rtl/mult_pkg.sv
// Shared definitions for the sequential unsigned multiplier.
// Opcode and FSM state encoding.
package mult_pkg;

  localparam logic [5:0] FUNCT_MULTU = 6'b011001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_addu_stage.sv
// Unsigned WIDTH-bit adder with carry out.
// One instance forms the shift-add accumulate step.
module mult_addu_stage #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // full-width add, carry kept for the product high half
  always_comb begin
    {carry, sum} = {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/seq_multu_unit.sv
// Sequential shift-add unsigned multiplier (MULTU), hi/lo result.
// Option: MULT_EARLY_DONE_EN ends early once multiplier bits run out.
module seq_multu_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state;
  state_t             state_nx;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_step;
  logic [2*WIDTH-1:0] p_nx;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic               accept;
  logic               last;

  assign ready  = (state == ST_IDLE) || (state == ST_DONE);
  assign busy   = (state == ST_BUSY);
  assign done   = (state == ST_DONE);
  assign accept = start && (funct == FUNCT_MULTU) && ready;
  assign addend = p[0] ? m : '0;

  mult_addu_stage #(
    .WIDTH(WIDTH)
  ) u_addu (
    .a     (p[2*WIDTH-1:WIDTH]),
    .b     (addend),
    .sum   (sum),
    .carry (carry)
  );

  assign p_step = {carry, sum, p[WIDTH-1:1]};

`ifdef MULT_EARLY_DONE_EN
  logic [WIDTH-1:0] rem_mask;
  logic             rem_zero;
  logic [CW-1:0]    sh;

  assign rem_mask = {WIDTH{1'b1}} >> cnt;
  assign rem_zero = ~|(p[WIDTH-1:0] & rem_mask);
  assign sh       = CW'(WIDTH) - cnt;
  assign last     = rem_zero || (cnt == CW'(WIDTH - 1));
  assign p_nx     = rem_zero ? (p >> sh) : p_step;
`else
  assign last = (cnt == CW'(WIDTH - 1));
  assign p_nx = p_step;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (accept) state_nx = ST_BUSY;
      ST_BUSY: if (last)   state_nx = ST_DONE;
      ST_DONE: state_nx = accept ? ST_BUSY : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // operand capture, shift-add steps, counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p   <= '0;
      m   <= '0;
      cnt <= '0;
    end else if (accept) begin
      p   <= {{WIDTH{1'b0}}, src2};
      m   <= src1;
      cnt <= '0;
    end else if (busy) begin
      p   <= p_nx;
      cnt <= cnt + CW'(1);
    end
  end

  // result registers, loaded only on the final step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (busy && last) begin
      hi <= p_nx[2*WIDTH-1:WIDTH];
      lo <= p_nx[WIDTH-1:0];
    end
  end

endmodule
